// File: rtl/reg_wb_arbiter_if.sv
// Write-back bundle between the execute-unit requesters / decode and the
// register-file write-port arbiter.
interface reg_wb_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [N_REQ-1:0]        ip_req_valid;
   logic [N_REQ*ADDR_W-1:0] ip_req_rd;
   logic [N_REQ*DATA_W-1:0] ip_req_data;
   logic [N_REQ-1:0]        op_req_ready;

   logic                    ip_iss_valid;
   logic                    ip_iss_rd_en;
   logic [ADDR_W-1:0]       ip_iss_rd;
   logic [ADDR_W-1:0]       ip_iss_rs1;
   logic [ADDR_W-1:0]       ip_iss_rs2;
   logic                    op_iss_stall;

   logic                    op_wr_en;
   logic [ADDR_W-1:0]       op_wr_addr;
   logic [DATA_W-1:0]       op_wr_data;
   logic [31:0]             op_busy;

   modport master (
      output ip_req_valid, ip_req_rd, ip_req_data,
      output ip_iss_valid, ip_iss_rd_en, ip_iss_rd, ip_iss_rs1, ip_iss_rs2,
      input  op_req_ready, op_iss_stall, op_wr_en, op_wr_addr, op_wr_data, op_busy
   );

   modport slave (
      input  ip_req_valid, ip_req_rd, ip_req_data,
      input  ip_iss_valid, ip_iss_rd_en, ip_iss_rd, ip_iss_rs1, ip_iss_rs2,
      output op_req_ready, op_iss_stall, op_wr_en, op_wr_addr, op_wr_data, op_busy
   );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a busy
// scoreboard of pending destination registers and RAW/WAW issue stall.
module reg_wb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic            ip_clk,
   input  logic            ip_rst,
   reg_wb_arbiter_if.slave wb
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [31:0]       busy_q, busy_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  gnt_idx;
   logic              found;
   logic              hs;
   logic [ADDR_W-1:0] hs_rd;
   logic [DATA_W-1:0] hs_data;
   logic              stall;
   logic              iss_accept;

   // Scan order ptr, ptr+1, ... wraps; slot j is visited at offset k when
   // ptr+k equals j either directly or after one wrap.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      hs_rd   = '0;
      hs_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && wb.ip_req_valid[j] &&
                ((int'(ptr_q) + k == j) || (int'(ptr_q) + k == j + N_REQ))) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               gnt_idx  = PTR_W'(j);
               hs_rd    = wb.ip_req_rd[j*ADDR_W +: ADDR_W];
               hs_data  = wb.ip_req_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign hs = found & ~ip_rst;

   always_comb begin
      stall = wb.ip_iss_valid &
              (busy_q[wb.ip_iss_rs1] | busy_q[wb.ip_iss_rs2] |
               (wb.ip_iss_rd_en & busy_q[wb.ip_iss_rd]));
      iss_accept = wb.ip_iss_valid & ~stall;
   end

   always_comb begin
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      if (hs) begin
         ptr_d     = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         wr_en_d   = (hs_rd != '0);
         wr_addr_d = hs_rd;
         wr_data_d = hs_data;
         busy_d[hs_rd] = 1'b0;
      end
      // Set after clear: an issue racing the retiring write owns the register.
      if (iss_accept && wb.ip_iss_rd_en && (wb.ip_iss_rd != '0))
         busy_d[wb.ip_iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         ptr_q     <= '0;
         busy_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wb.op_req_ready = ip_rst ? '0 : grant;
   assign wb.op_iss_stall = stall;
   assign wb.op_wr_en     = wr_en_q;
   assign wb.op_wr_addr   = wr_addr_q;
   assign wb.op_wr_data   = wr_data_q;
   assign wb.op_busy      = busy_q;
endmodule
